// File: rtl/data_mem_resp_pkg.sv
// Shared constants for the data-memory responder and its compare timer.
// DMEM_TIMER_PRESCALE_EN adds the TPRE register to the timer block.
package data_mem_resp_pkg;

   localparam int TOFS_W  = 3;
   localparam int TCTRL_W = 3;

   typedef enum logic [TOFS_W-1:0] {
      TCTRL_OFS = 3'd0,
      TCNT_OFS  = 3'd1,
      TCMP_OFS  = 3'd2,
      TSTAT_OFS = 3'd3,
      TPRE_OFS  = 3'd4
   } treg_ofs_e;

   localparam int EN_BIT   = 0;
   localparam int AUTO_BIT = 1;
   localparam int IE_BIT   = 2;

   localparam int INT_TIMER_BIT = 0;

   localparam logic [15:0] DEF_TIMER_BASE = 16'hFF00;

`ifdef DMEM_TIMER_PRESCALE_EN
   localparam int N_TREGS = 5;
`else
   localparam int N_TREGS = 4;
`endif

endpackage

// File: rtl/dmem_timer.sv
// Compare timer: TCTRL/TCNT/TCMP/TSTAT registers plus the timer interrupt.
// DMEM_TIMER_PRESCALE_EN adds TPRE and an internal prescale counter.
module dmem_timer
   import data_mem_resp_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sel,
   input  logic [TOFS_W-1:0] ofs,
   input  logic [DATA_W-1:0] wd,
   input  logic              we,
   output logic [DATA_W-1:0] rd,
   output logic              irq
);

   logic [TCTRL_W-1:0] tctrl_reg, tctrl_next;
   logic [DATA_W-1:0]  tcnt_reg, tcnt_next;
   logic [DATA_W-1:0]  tcmp_reg, tcmp_next;
   logic               pend_reg, pend_next;

   logic wr_tctrl, wr_tcnt, wr_tcmp, wr_tstat;
   logic tick, match;

   assign wr_tctrl = sel && we && (ofs == TCTRL_OFS);
   assign wr_tcnt  = sel && we && (ofs == TCNT_OFS);
   assign wr_tcmp  = sel && we && (ofs == TCMP_OFS);
   assign wr_tstat = sel && we && (ofs == TSTAT_OFS);

   assign match = (tcnt_reg == tcmp_reg);

`ifdef DMEM_TIMER_PRESCALE_EN
   logic [DATA_W-1:0] tpre_reg, tpre_next;
   logic [DATA_W-1:0] pcnt_reg, pcnt_next;
   logic              wr_tpre;

   assign wr_tpre = sel && we && (ofs == TPRE_OFS);
   assign tick    = tctrl_reg[EN_BIT] && (pcnt_reg == tpre_reg);

   // A TCNT write restarts the prescale period so the new count gets a full one.
   always_comb begin
      tpre_next = wr_tpre ? wd : tpre_reg;
      if (!tctrl_reg[EN_BIT] || wr_tcnt || tick)
         pcnt_next = '0;
      else
         pcnt_next = pcnt_reg + DATA_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tpre_reg <= '0;
         pcnt_reg <= '0;
      end else begin
         tpre_reg <= tpre_next;
         pcnt_reg <= pcnt_next;
      end
   end
`else
   assign tick = tctrl_reg[EN_BIT];
`endif

   // Priority order: W1C first so a same-cycle match set wins, then core
   // writes last so they override reload, increment and the one-shot EN clear.
   always_comb begin
      tctrl_next = tctrl_reg;
      tcnt_next  = tcnt_reg;
      tcmp_next  = tcmp_reg;
      pend_next  = pend_reg & ~(wr_tstat & wd[0]);

      if (tick) begin
         if (match) begin
            pend_next = 1'b1;
            if (tctrl_reg[AUTO_BIT])
               tcnt_next = '0;
            else
               tctrl_next[EN_BIT] = 1'b0;
         end else begin
            tcnt_next = tcnt_reg + DATA_W'(1);
         end
      end

      if (wr_tctrl) tctrl_next = wd[TCTRL_W-1:0];
      if (wr_tcnt)  tcnt_next  = wd;
      if (wr_tcmp)  tcmp_next  = wd;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tctrl_reg <= '0;
         tcnt_reg  <= '0;
         tcmp_reg  <= '0;
         pend_reg  <= 1'b0;
      end else begin
         tctrl_reg <= tctrl_next;
         tcnt_reg  <= tcnt_next;
         tcmp_reg  <= tcmp_next;
         pend_reg  <= pend_next;
      end
   end

   always_comb begin
      rd = '0;
      case (ofs)
         TCTRL_OFS: rd = DATA_W'(tctrl_reg);
         TCNT_OFS:  rd = tcnt_reg;
         TCMP_OFS:  rd = tcmp_reg;
         TSTAT_OFS: rd = DATA_W'(pend_reg);
`ifdef DMEM_TIMER_PRESCALE_EN
         TPRE_OFS:  rd = tpre_reg;
`endif
         default:   rd = '0;
      endcase
   end

   assign irq = pend_reg & tctrl_reg[IE_BIT];

endmodule

// File: rtl/data_mem_resp.sv
// Data-memory responder: word RAM with asynchronous read plus a mapped timer.
// DMEM_TIMER_PRESCALE_EN enables the timer prescaler register TPRE.
module data_mem_resp
   import data_mem_resp_pkg::*;
#(
   parameter int                DATA_W     = 16,
   parameter int                ADDR_W     = 16,
   parameter int                RAM_DEPTH  = 1024,
   parameter logic [ADDR_W-1:0] TIMER_BASE = ADDR_W'(DEF_TIMER_BASE),
   parameter int                INT_W      = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wd,
   input  logic              mem_ctrl,
   output logic [DATA_W-1:0] mem_rd,
   output logic [INT_W-1:0]  int_o
);

   localparam int RAM_AW = $clog2(RAM_DEPTH);

   logic [DATA_W-1:0] ram_mem [RAM_DEPTH];
   logic [RAM_AW-1:0] ram_idx;
   logic              ram_sel;
   logic              timer_sel;
   logic [ADDR_W-1:0] timer_ofs_full;
   logic [DATA_W-1:0] timer_rd;
   logic              timer_irq;

   assign ram_sel        = 32'(mem_addr) < 32'(RAM_DEPTH);
   assign ram_idx        = mem_addr[RAM_AW-1:0];
   assign timer_ofs_full = mem_addr - TIMER_BASE;
   assign timer_sel      = (mem_addr >= TIMER_BASE) &&
                           (timer_ofs_full < ADDR_W'(N_TREGS));

   // Contents are deliberately left out of reset; a same-cycle read sees old data.
   always_ff @(posedge clk) begin
      if (mem_ctrl && ram_sel)
         ram_mem[ram_idx] <= mem_wd;
   end

   dmem_timer #(
      .DATA_W (DATA_W)
   ) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .sel   (timer_sel),
      .ofs   (timer_ofs_full[TOFS_W-1:0]),
      .wd    (mem_wd),
      .we    (mem_ctrl),
      .rd    (timer_rd),
      .irq   (timer_irq)
   );

   always_comb begin
      if (ram_sel)
         mem_rd = ram_mem[ram_idx];
      else if (timer_sel)
         mem_rd = timer_rd;
      else
         mem_rd = '0;
   end

   generate
      for (genvar gi = 0; gi < INT_W; gi++) begin : g_int
         if (gi == INT_TIMER_BIT) begin : g_timer
            assign int_o[gi] = timer_irq;
         end else begin : g_tie
            assign int_o[gi] = 1'b0;
         end
      end
   endgenerate

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed and random checks of data_mem_resp against a cycle-level reference model.
// Build with DMEM_TIMER_PRESCALE_EN to include the prescaler steps.
module tb_data_mem_resp;

   localparam logic [15:0] TB = 16'hFF00;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] mem_addr, mem_wd, mem_rd;
   logic        mem_ctrl;
   logic [7:0]  int_o;

   int total_cnt = 0;
   int pass_cnt  = 0;

   always #5 clk = ~clk;

   data_mem_resp dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .mem_addr (mem_addr),
      .mem_wd   (mem_wd),
      .mem_ctrl (mem_ctrl),
      .mem_rd   (mem_rd),
      .int_o    (int_o)
   );

   // Reference state: RAM words written so far, and timer fields by name.
   logic [15:0] m_ram [int];
   int          m_tcnt, m_tcmp, m_tpre, m_pcnt;
   bit          m_en, m_auto, m_ie, m_pend;

   function automatic bit m_read(input logic [15:0] a, output logic [15:0] v);
      v = 16'd0;
      if (a < 16'd1024) begin
         if (!m_ram.exists(int'(a))) return 1'b0;
         v = m_ram[int'(a)];
         return 1'b1;
      end
      if (a == TB)              v = {13'd0, m_ie, m_auto, m_en};
      else if (a == TB + 16'd1) v = 16'(m_tcnt);
      else if (a == TB + 16'd2) v = 16'(m_tcmp);
      else if (a == TB + 16'd3) v = {15'd0, m_pend};
`ifdef DMEM_TIMER_PRESCALE_EN
      else if (a == TB + 16'd4) v = 16'(m_tpre);
`endif
      return 1'b1;
   endfunction

   task automatic m_step(input logic [15:0] a, input logic [15:0] wd, input bit we, input bit rstn);
      bit tick;
      int n_tcnt, n_pcnt;
      bit n_en, n_pend;
      if (we && a < 16'd1024) m_ram[int'(a)] = wd;
      if (!rstn) begin
         m_tcnt = 0; m_tcmp = 0; m_tpre = 0; m_pcnt = 0;
         m_en = 0; m_auto = 0; m_ie = 0; m_pend = 0;
         return;
      end
`ifdef DMEM_TIMER_PRESCALE_EN
      tick = m_en && (m_pcnt == m_tpre);
      n_pcnt = (!m_en || tick || (we && a == TB + 16'd1)) ? 0 : m_pcnt + 1;
`else
      tick = m_en;
      n_pcnt = 0;
`endif
      n_tcnt = m_tcnt;
      n_en   = m_en;
      n_pend = m_pend && !(we && a == TB + 16'd3 && wd[0]);
      if (tick && m_tcnt == m_tcmp) begin
         n_pend = 1;
         if (m_auto) n_tcnt = 0;
         else        n_en = 0;
      end else if (tick) begin
         n_tcnt = (m_tcnt + 1) % 65536;
      end
      m_pcnt = n_pcnt;
      m_tcnt = n_tcnt;
      m_en   = n_en;
      m_pend = n_pend;
      if (we && a == TB) begin
         m_en = wd[0]; m_auto = wd[1]; m_ie = wd[2];
      end
      if (we && a == TB + 16'd1) m_tcnt = int'(wd);
      if (we && a == TB + 16'd2) m_tcmp = int'(wd);
`ifdef DMEM_TIMER_PRESCALE_EN
      if (we && a == TB + 16'd4) m_tpre = int'(wd);
`endif
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // One bus cycle: check read data and irq before the edge, then advance the model.
   task automatic do_op(input logic [15:0] a, input logic [15:0] wd, input bit we, input string tag);
      logic [15:0] ev;
      bit known;
      mem_addr = a; mem_wd = wd; mem_ctrl = we;
      #1;
      known = m_read(a, ev);
      if (known) chk({tag, "_rd"}, mem_rd, ev);
      chk({tag, "_int"}, 16'(int_o), {15'd0, m_pend & m_ie});
      @(posedge clk);
      m_step(a, wd, we, rst_n);
      #1;
   endtask

   task automatic rd(input logic [15:0] a, input string tag);
      do_op(a, 16'd0, 1'b0, tag);
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] wd, input string tag);
      do_op(a, wd, 1'b1, tag);
   endtask

   // Combinational look with no clock advance, against a literal expectation.
   task automatic peek(input logic [15:0] a, input logic [15:0] exp, input string tag);
      mem_addr = a; mem_ctrl = 1'b0;
      #1;
      chk(tag, mem_rd, exp);
   endtask

   initial begin
      logic [15:0] ra [16];
      logic [15:0] a, d;
      int          sel;

      rst_n = 1'b0; mem_addr = 16'd0; mem_wd = 16'd0; mem_ctrl = 1'b0;
      repeat (3) begin
         @(posedge clk);
         m_step(16'd0, 16'd0, 1'b0, 1'b0);
      end
      #1;
      rst_n = 1'b1;

      for (int i = 0; i < 4; i++) peek(TB + 16'(i), 16'd0, "reset_reg");
      chk("reset_int", 16'(int_o), 16'd0);

      wr(16'd5, 16'hA5A5, "ram_wr");
      rd(16'd5, "ram_rd");
      peek(16'd5, 16'hA5A5, "ram5");
      rd(16'h8000, "unmapped_rd");
      wr(16'h8000, 16'hFFFF, "unmapped_wr");
      peek(16'h8000, 16'd0, "unmapped_drop");
      wr(TB + 16'd5, 16'h1234, "tb5_wr");
      peek(TB + 16'd5, 16'd0, "tb5_drop");
      wr(16'd5, 16'h1234, "ram_old_data");
      peek(16'd5, 16'h1234, "ram5_new");

      for (int i = 0; i < 16; i++) begin
         ra[i] = 16'($urandom_range(6, 1023));
         wr(ra[i], 16'($urandom), "ram_rand_wr");
      end
      for (int i = 0; i < 16; i++) rd(ra[i], "ram_rand_rd");

      // Auto-reload: TCNT runs 0,1,2,3,0,... and PEND sets on the 3->0 edge.
      wr(TB + 16'd2, 16'd3, "auto_cmp");
      wr(TB, 16'd7, "auto_ctrl");
      for (int i = 0; i < 10; i++) begin
         peek(TB + 16'd1, 16'(i % 4), "auto_seq");
         chk("auto_int", 16'(int_o), (i >= 4) ? 16'd1 : 16'd0);
         rd(TB + 16'd1, "auto_tcnt");
      end
      wr(TB, 16'd4, "auto_stop");
      wr(TB + 16'd3, 16'd1, "auto_w1c");
      rd(TB + 16'd3, "auto_stat");
      chk("w1c_int", 16'(int_o), 16'd0);

      // One-shot with and without IE.
      wr(TB + 16'd1, 16'd0, "os_cnt");
      wr(TB + 16'd2, 16'd2, "os_cmp");
      wr(TB, 16'd5, "os_ctrl");
      repeat (6) rd(TB + 16'd1, "os_tcnt");
      peek(TB, 16'd4, "os_tctrl");
      peek(TB + 16'd1, 16'd2, "os_hold");
      peek(TB + 16'd3, 16'd1, "os_pend");
      chk("os_int", 16'(int_o), 16'd1);
      wr(TB + 16'd3, 16'd1, "os_w1c");
      wr(TB + 16'd1, 16'd0, "os2_cnt");
      wr(TB, 16'd1, "os2_ctrl");
      repeat (6) rd(TB + 16'd3, "os2_stat");
      peek(TB + 16'd3, 16'd1, "os2_pend");
      chk("os2_int", 16'(int_o), 16'd0);

      // Contention: W1C in the same cycle as a match, then a TCNT write mid-count.
      wr(TB + 16'd3, 16'd1, "ct_clr");
      wr(TB + 16'd1, 16'd0, "ct_cnt");
      wr(TB + 16'd2, 16'd4, "ct_cmp");
      wr(TB, 16'd3, "ct_ctrl");
      repeat (4) rd(TB + 16'd1, "ct_tcnt");
      peek(TB + 16'd1, 16'd4, "ct_at_match");
      wr(TB + 16'd3, 16'd1, "ct_w1c_match");
      peek(TB + 16'd3, 16'd1, "ct_set_wins");
      wr(TB + 16'd2, 16'd100, "ct_cmp100");
      wr(TB + 16'd1, 16'd10, "ct_tcnt_wr");
      peek(TB + 16'd1, 16'd10, "ct_tcnt10");
      rd(TB + 16'd1, "ct_tcnt_rd");
      peek(TB + 16'd1, 16'd11, "ct_tcnt11");

      // Random mix of timer, RAM and unmapped accesses.
      for (int i = 0; i < 300; i++) begin
         sel = int'($urandom_range(0, 9));
         if (sel <= 5) begin
            a = TB + 16'(sel);
            case (sel)
               0:       d = 16'($urandom_range(0, 15));
               1, 2:    d = 16'($urandom_range(0, 6));
               3:       d = 16'($urandom_range(0, 1));
               default: d = 16'($urandom_range(0, 2));
            endcase
            do_op(a, d, bit'($urandom_range(0, 1)), "rnd_timer");
         end else if (sel <= 7) begin
            a = 16'($urandom_range(6, 1023));
            do_op(a, 16'($urandom), bit'($urandom_range(0, 1)), "rnd_ram");
         end else if (sel == 8) begin
            do_op(16'($urandom_range(1024, 16'hFEFF)), 16'($urandom), bit'($urandom_range(0, 1)), "rnd_unmap");
         end else begin
            rd(TB + 16'd1, "rnd_tcnt");
         end
      end

      // Reset mid-count with TCNT=7 and PEND=1.
      wr(TB, 16'd0, "rs_stop");
      wr(TB + 16'd4, 16'd0, "rs_tpre");
      wr(TB + 16'd3, 16'd1, "rs_clr");
      wr(TB + 16'd1, 16'd5, "rs_cnt");
      wr(TB + 16'd2, 16'd5, "rs_cmp");
      wr(TB, 16'd7, "rs_ctrl");
      rd(TB + 16'd1, "rs_match");
      wr(TB + 16'd2, 16'd100, "rs_cmp100");
      wr(TB + 16'd1, 16'd6, "rs_cnt6");
      rd(TB + 16'd1, "rs_tcnt");
      peek(TB + 16'd1, 16'd7, "rs_tcnt7");
      peek(TB + 16'd3, 16'd1, "rs_pend1");
      rst_n = 1'b0;
      rd(TB + 16'd1, "rs_in_reset");
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) peek(TB + 16'(i), 16'd0, "rs_reg0");
      chk("rs_int0", 16'(int_o), 16'd0);
      peek(16'd5, 16'h1234, "rs_ram_kept");
      rd(16'd5, "rs_ram_rd");

`ifdef DMEM_TIMER_PRESCALE_EN
      wr(TB + 16'd4, 16'd2, "pre_tpre");
      peek(TB + 16'd4, 16'd2, "pre_tpre_rd");
      wr(TB + 16'd2, 16'd1, "pre_cmp");
      wr(TB, 16'd3, "pre_ctrl");
      repeat (3) rd(TB + 16'd1, "pre_tcnt");
      peek(TB + 16'd1, 16'd1, "pre_tcnt1");
      repeat (2) rd(TB + 16'd3, "pre_stat");
      peek(TB + 16'd3, 16'd0, "pre_pend0");
      rd(TB + 16'd3, "pre_stat6");
      peek(TB + 16'd3, 16'd1, "pre_pend1");
`else
      wr(TB + 16'd4, 16'd5, "tpre_unmapped");
      peek(TB + 16'd4, 16'd0, "tpre_drop");
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
